fetch_prefetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word reads to a multi-cycle instruction memory using a req/ack handshake. Returned instructions, each with its PC+4, go into a small FIFO that the pipeline drains under its stall control. Branch redirects from ID flush the FIFO and any in-flight read.

---
 rtl/fetch_prefetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: owns fetch PC, issues imem reads, buffers {instr, pc+4} in a FIFO.
// Latency: first instruction valid 3 cycles after reset release with a 1-cycle memory; 1 instr / 2 cycles sustained.
// Backpressure: if_ready drains the FIFO; no new request is issued unless a FIFO slot is free. Optional FETCH_PERF_EN adds perf counters.
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_redirects,
  output logic [15:0]       perf_empty_cycles
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  entry_t            fifo_mem [DEPTH];

  logic              push;
  logic              pop;
  logic [31:0]       pc_plus4;
  logic [31:0]       redirect_tgt;
  logic [31:0]       next_req_pc;
  logic [CW-1:0]     count_after_ack;
  entry_t            head;

  assign pc_plus4     = fetch_pc_q + 32'd4;
  // Branch targets are word aligned; the low two bits of the target are dropped.
  assign redirect_tgt = redirect_pc & ~32'h3;
  assign pop          = (count_q != '0) && if_ready;
  // Occupancy after this cycle's ack push and any pop, used to decide a back-to-back issue.
  assign count_after_ack = count_q + CW'(1) - CW'(pop);

  // Fetch FSM: next state, next fetch PC, request address and push decision.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    push        = 1'b0;
    next_req_pc = pc_plus4;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
          addr_d  = fetch_pc_q[ADDR_W+1:2];
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // An in-flight read cannot be aborted; its data is thrown away.
          fetch_pc_d = redirect_tgt;
          state_d    = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
          if (count_after_ack < DEPTH_C) begin
            state_d = REQ;
            addr_d  = next_req_pc[ADDR_W+1:2];
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a redirect empties the queue after any same-cycle pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset since empty entries are masked at the output.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{instr: imem_rdata, pc4: pc_plus4};
    end
  end

  assign head      = fifo_mem[rd_ptr_q];
  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign if_valid  = (count_q != '0);
  assign if_instr  = if_valid ? head.instr : 32'd0;
  assign if_pc4    = if_valid ? head.pc4   : 32'd0;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_redirects_q;
  logic [15:0] perf_empty_q;

  // Saturating counters: redirect cycles and cycles the pipeline wanted an instruction but none was ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_redirects_q <= '0;
      perf_empty_q     <= '0;
    end else begin
      if (redirect_valid && (perf_redirects_q != 16'hFFFF)) begin
        perf_redirects_q <= perf_redirects_q + 16'd1;
      end
      if (!if_valid && if_ready && (perf_empty_q != 16'hFFFF)) begin
        perf_empty_q <= perf_empty_q + 16'd1;
      end
    end
  end

  assign perf_redirects    = perf_redirects_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit with a behavioural instruction memory.
// Memory acks mem_lat cycles after a request first appears; data is a function of the address.
// Inputs change and outputs are sampled 1ns after the falling clock edge.
module tb_fetch_prefetch_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'd0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          if_ready = 1'b0;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc4;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_redirects;
  logic [15:0]   perf_empty_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int age = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(4), .ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {22'd0, a};
  endfunction

  // Memory model: ack after mem_lat cycles of a held request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (age == mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mdata(imem_addr);
        ack_cnt++;
        age = 0;
      end else begin
        imem_ack = 1'b0;
        age++;
      end
    end else begin
      imem_ack = 1'b0;
      age = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    if_ready = rdy;
    repeat (2) step();
    mem_lat = lat;
    ack_cnt = 0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_instr); end
    checks++; if (if_pc4 !== 32'd0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", if_pc4); end
  endtask

  task automatic test_stream();
    int exp_addr = 0;
    logic [31:0] exp_pc4 = 32'd4;
    int first = -1;
    int npop = 0;
    do_reset(1, 1'b1);
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    for (int c = 2; c <= 14; c++) begin
      step();
      if (imem_ack) begin
        checks++; if (imem_addr !== AW'(exp_addr)) begin errors++; $display("FAIL stream_addr: got %h expected %h", imem_addr, AW'(exp_addr)); end
        exp_addr++;
      end
      if (if_valid) begin
        if (first < 0) first = c;
        checks++; if (if_pc4 !== exp_pc4 || if_instr !== mdata(AW'((exp_pc4 >> 2) - 1))) begin
          errors++; $display("FAIL stream_data: got pc4=%h instr=%h expected pc4=%h instr=%h", if_pc4, if_instr, exp_pc4, mdata(AW'((exp_pc4 >> 2) - 1)));
        end
        exp_pc4 += 32'd4;
        npop++;
      end
    end
    checks++; if (first != 3) begin errors++; $display("FAIL stream_first_valid: got cycle %0d expected 3", first); end
    checks++; if (npop != 6) begin errors++; $display("FAIL stream_pops: got %0d expected 6", npop); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc4 = 32'd4;
    do_reset(0, 1'b1);
    step();
    for (int c = 2; c <= 8; c++) begin
      step();
      checks++; if (if_valid !== 1'b1 || if_pc4 !== exp_pc4) begin
        errors++; $display("FAIL b2b_cycle%0d: got valid=%b pc4=%h expected valid=1 pc4=%h", c, if_valid, if_pc4, exp_pc4);
      end
      exp_pc4 += 32'd4;
    end
  endtask

  task automatic test_full();
    int npop = 0;
    int fourth = -1;
    do_reset(1, 1'b0);
    repeat (20) step();
    checks++; if (ack_cnt != 4) begin errors++; $display("FAIL full_acks: got %0d expected 4", ack_cnt); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b expected 0", imem_req); end
    checks++; if (if_valid !== 1'b1 || if_pc4 !== 32'd4) begin errors++; $display("FAIL full_head: got valid=%b pc4=%h expected valid=1 pc4=4", if_valid, if_pc4); end
    if_ready = 1'b1;
    for (int c = 0; c < 30 && npop < 6; c++) begin
      if (if_valid) begin
        checks++; if (if_pc4 !== 32'(4 * (npop + 1))) begin errors++; $display("FAIL full_drain: got pc4=%h expected %h", if_pc4, 32'(4 * (npop + 1))); end
        npop++;
        if (npop == 4) fourth = c;
      end
      step();
    end
    checks++; if (npop != 6) begin errors++; $display("FAIL full_drain_count: got %0d expected 6", npop); end
    checks++; if (fourth != 3) begin errors++; $display("FAIL full_drain_burst: got 4th pop at %0d expected 3", fourth); end
  endtask

  task automatic test_redirect_drain();
    logic leak = 1'b0;
    logic found = 1'b0;
    logic got = 1'b0;
    do_reset(3, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL drain_hold: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    for (int c = 0; c < 20 && !found; c++) begin
      if (if_valid) leak = 1'b1;
      if (imem_req && imem_addr == AW'(10'h040)) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL drain_target_req: got no request to 040 expected one"); end
    checks++; if (leak) begin errors++; $display("FAIL drain_discard: got if_valid=1 expected 0 before target fetch"); end
    for (int c = 0; c < 20 && !got; c++) begin
      if (if_valid) got = 1'b1;
      else step();
    end
    checks++; if (!got || if_pc4 !== 32'h104 || if_instr !== mdata(AW'(10'h040))) begin
      errors++; $display("FAIL drain_new_data: got valid=%b pc4=%h instr=%h expected valid=1 pc4=104 instr=%h", if_valid, if_pc4, if_instr, mdata(AW'(10'h040)));
    end
  endtask

  task automatic test_redirect_ack();
    logic got = 1'b0;
    do_reset(1, 1'b1);
    step();
    step();
    checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL rack_setup: got ack=%b expected 1", imem_ack); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rack_discard: got req=%b valid=%b expected req=0 valid=0", imem_req, if_valid); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== AW'(10'h080)) begin errors++; $display("FAIL rack_target: got req=%b addr=%h expected req=1 addr=080", imem_req, imem_addr); end
    for (int c = 0; c < 10 && !got; c++) begin
      if (if_valid) got = 1'b1;
      else step();
    end
    checks++; if (!got || if_pc4 !== 32'h204) begin errors++; $display("FAIL rack_data: got valid=%b pc4=%h expected valid=1 pc4=204", if_valid, if_pc4); end
  endtask

  task automatic test_pop_redirect();
    logic found = 1'b0;
    do_reset(1, 1'b0);
    repeat (7) step();
    checks++; if (ack_cnt != 3 || if_valid !== 1'b1 || if_pc4 !== 32'd4) begin
      errors++; $display("FAIL popr_setup: got acks=%0d valid=%b pc4=%h expected acks=3 valid=1 pc4=4", ack_cnt, if_valid, if_pc4);
    end
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL popr_flush: got valid=%b expected 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL popr_flush2: got valid=%b expected 0", if_valid); end
    for (int c = 0; c < 10 && !found; c++) begin
      if (imem_req && imem_addr == AW'(10'h0C0)) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL popr_target: got no request to 0C0 expected one"); end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1'b1);
    repeat (5) step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== AW'(2)) begin errors++; $display("FAIL rmid_setup: got req=%b addr=%h expected req=1 addr=2", imem_req, imem_addr); end
    reset = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== '0 || if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc4 !== 32'd0) begin
      errors++; $display("FAIL rmid_outputs: got req=%b addr=%h valid=%b instr=%h pc4=%h expected all 0", imem_req, imem_addr, if_valid, if_instr, if_pc4);
    end
    reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset(1, 1'b0);
    checks++; if (perf_redirects !== 16'd0 || perf_empty_cycles !== 16'd0) begin
      errors++; $display("FAIL perf_reset: got red=%0d empty=%0d expected 0 0", perf_redirects, perf_empty_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1;
      redirect_pc = 32'(i * 16);
      step();
    end
    redirect_valid = 1'b0;
    step();
    checks++; if (perf_redirects !== 16'd3) begin errors++; $display("FAIL perf_redirects: got %0d expected 3", perf_redirects); end
    checks++; if (perf_empty_cycles !== 16'd0) begin errors++; $display("FAIL perf_empty: got %0d expected 0", perf_empty_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_full();
    test_redirect_drain();
    test_redirect_ack();
    test_pop_redirect();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
